// File: rtl/draw_pkg.sv
// Shared widths, constants and state encoding for the draw-manager write path.
package draw_pkg;
    localparam int SOURCE_SEL_ADDRW  = 3;
    localparam int COLOR_DEPTH       = 8;
    localparam int DRAW_WIDTH        = 640;
    localparam int DRAW_HEIGHT       = 480;
    localparam int DRAW_WIDTH_ADDRW  = 10;
    localparam int DRAW_HEIGHT_ADDRW = 9;
    localparam int FB_ADDRW          = 19;

    // All-ones select value is reserved to mean "nobody owns the bus".
    localparam logic [SOURCE_SEL_ADDRW-1:0] SOURCE_NONE = '1;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_STREAM,
        ARB_NEXT,
        ARB_DONE
    } arb_state_t;

    function automatic logic [FB_ADDRW-1:0] fb_linear_addr(
        input logic [DRAW_WIDTH_ADDRW-1:0]  x,
        input logic [DRAW_HEIGHT_ADDRW-1:0] y
    );
        return FB_ADDRW'(y) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(x);
    endfunction
endpackage

// File: rtl/draw_pixel_sink.sv
// Clips captured pixels, forms the linear framebuffer address and registers the write.
// Build option DRAW_ARB_STATS_EN adds written/dropped pixel counters.
module draw_pixel_sink
    import draw_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         cap_i,
    input  logic [COLOR_DEPTH-1:0]       color_i,
    input  logic                         transparent_i,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  x_i,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] y_i,
`ifdef DRAW_ARB_STATS_EN
    input  logic                         stat_clr_i,
    output logic [FB_ADDRW-1:0]          stat_written_o,
    output logic [FB_ADDRW-1:0]          stat_dropped_o,
`endif
    output logic                         fb_we_o,
    output logic [FB_ADDRW-1:0]          fb_addr_o,
    output logic [COLOR_DEPTH-1:0]       fb_data_o,
    output logic                         pipe_empty_o
);
    localparam logic [DRAW_WIDTH_ADDRW:0]  X_LIM = (DRAW_WIDTH_ADDRW + 1)'(DRAW_WIDTH);
    localparam logic [DRAW_HEIGHT_ADDRW:0] Y_LIM = (DRAW_HEIGHT_ADDRW + 1)'(DRAW_HEIGHT);

    logic                   visible;
    logic                   wr_d;
    logic                   fb_we_q;
    logic [FB_ADDRW-1:0]    fb_addr_q;
    logic [COLOR_DEPTH-1:0] fb_data_q;

    assign visible = !transparent_i && ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);
    assign wr_d    = cap_i && visible;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_we_q <= wr_d;
            if (wr_d) begin
                fb_addr_q <= fb_linear_addr(x_i, y_i);
                fb_data_q <= color_i;
            end
        end
    end

    assign fb_we_o      = fb_we_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;
    // Single register stage, so the pipe is empty whenever no write is presented.
    assign pipe_empty_o = !fb_we_q;

`ifdef DRAW_ARB_STATS_EN
    logic [FB_ADDRW-1:0] stat_written_q;
    logic [FB_ADDRW-1:0] stat_dropped_q;

    // Captures only occur inside a round, so the counts hold on their own after frame_done.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stat_written_q <= '0;
            stat_dropped_q <= '0;
        end else if (stat_clr_i) begin
            stat_written_q <= '0;
            stat_dropped_q <= '0;
        end else if (cap_i) begin
            if (visible) stat_written_q <= stat_written_q + FB_ADDRW'(1);
            else         stat_dropped_q <= stat_dropped_q + FB_ADDRW'(1);
        end
    end

    assign stat_written_o = stat_written_q;
    assign stat_dropped_o = stat_dropped_q;
`endif
endmodule

// File: rtl/draw_write_arbiter.sv
// Write-bus arbiter: grants every draw source in turn each frame and forwards its pixels.
// Build option DRAW_ARB_STATS_EN exposes per-frame written/dropped pixel counts.
module draw_write_arbiter
    import draw_pkg::*;
#(
    parameter int SOURCES_COUNT = 4,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         source_timeout,
    output logic                         frame_overrun,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [FB_ADDRW-1:0]          fb_addr,
    output logic [COLOR_DEPTH-1:0]       fb_data
`ifdef DRAW_ARB_STATS_EN
    ,
    output logic [FB_ADDRW-1:0]          stat_written,
    output logic [FB_ADDRW-1:0]          stat_dropped
`endif
);
    // state  | meaning
    // IDLE   | no round running; bus ignored
    // GRANT  | src_q selected, waiting for its first pixel
    // STREAM | src_q streaming; first idle cycle ends its turn
    // NEXT   | one-cycle gap, bus deselected
    // DONE   | waiting for the last write to drain, then frame_done

    localparam int CNT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_LAST = SOURCE_SEL_ADDRW'(SOURCES_COUNT - 1);

    arb_state_t                  state_q, state_d;
    logic [SOURCE_SEL_ADDRW-1:0] src_q, src_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        timeout_q, timeout_d;
    logic                        overrun_q, overrun_d;
    logic                        act;
    logic                        cap;
    logic                        accept;
    logic                        pipe_empty;

    // A floating or unknown bus line must read as inactive.
    always_comb begin
        act = 1'b0;
        if (write_active == 1'b1) act = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        cap       = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (frame_start) begin
                    accept  = 1'b1;
                    state_d = ARB_GRANT;
                    src_d   = '0;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (act) begin
                    cap     = 1'b1;
                    state_d = ARB_STREAM;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ARB_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_STREAM: begin
                if (act) cap = 1'b1;
                else     state_d = ARB_NEXT;
            end
            ARB_NEXT: begin
                if (src_q == SRC_LAST) begin
                    state_d = ARB_DONE;
                end else begin
                    src_d   = src_q + SOURCE_SEL_ADDRW'(1);
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_DONE: begin
                if (pipe_empty) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_q != ARB_IDLE);
        frame_done       = (state_q == ARB_DONE) && pipe_empty;
        write_awaited    = (state_q == ARB_GRANT);
        write_source_sel = SOURCE_NONE;
        if (state_q == ARB_GRANT || state_q == ARB_STREAM) write_source_sel = src_q;
    end

    // busy already covers the frame_done cycle, so a coincident frame_start is an overrun.
    assign overrun_d = overrun_q | (frame_start & busy);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ARB_IDLE;
            src_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign source_timeout = timeout_q;
    assign frame_overrun  = overrun_q;

    draw_pixel_sink u_sink (
        .clk           (clk),
        .resetN        (resetN),
        .cap_i         (cap),
        .color_i       (write_color_data),
        .transparent_i (write_transparent),
        .x_i           (write_x_addr),
        .y_i           (write_y_addr),
`ifdef DRAW_ARB_STATS_EN
        .stat_clr_i    (accept),
        .stat_written_o(stat_written),
        .stat_dropped_o(stat_dropped),
`endif
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data),
        .pipe_empty_o  (pipe_empty)
    );
endmodule
